// File: rtl/gpmc_bridge_pkg.sv
// Shared types for the GPMC register-file bridge: FSM state and data-phase beat decode.
package gpmc_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } gpmc_state_e;

  typedef enum logic [1:0] {
    BEAT_NONE,
    BEAT_WR,
    BEAT_RD,
    BEAT_ERR
  } gpmc_beat_e;

  // Classify a data-phase cycle from the active-low strobes {wein, oen}.
  function automatic gpmc_beat_e decode_beat(input logic wein, input logic oen);
    case ({wein, oen})
      2'b01:   return BEAT_WR;
      2'b10:   return BEAT_RD;
      2'b00:   return BEAT_ERR;
      default: return BEAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpmc_reg_bank.sv
// Register storage with byte-enable merge, read-only status mux and out-of-range read data.
module gpmc_reg_bank
  import gpmc_bridge_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH = 4,
  parameter int unsigned                DATA_WIDTH = 16,
  parameter int unsigned                NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0]      OOR_DATA   = DATA_WIDTH'(16'hBADD)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wr_en,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_be_n,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_regs_in,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_in_range,
  output logic                           o_writable,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs_out
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_idx      = IW'(i_addr);
  assign o_in_range = (32'(i_addr) < NUM_REGS);
  assign o_writable = o_in_range && !RO_MASK[w_idx];
  assign w_cur      = r_regs[w_idx];

  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign w_merged[b*8 +: 8] = i_be_n[b] ? w_cur[b*8 +: 8] : i_wdata[b*8 +: 8];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign o_regs_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
    end else if (i_wr_en && o_writable) begin
      r_regs[w_idx] <= w_merged;
    end
  end

  always_comb begin
    o_rdata = OOR_DATA;
    if (o_in_range) begin
      o_rdata = RO_MASK[w_idx] ? i_regs_in[w_idx*DATA_WIDTH +: DATA_WIDTH] : r_regs[w_idx];
    end
  end

endmodule

// File: rtl/gpmc_regfile_bridge.sv
// GPMC multiplexed-AD slave in front of a NUM_REGS register file.
// Define GPMC_BURST_EN to auto-increment the address pointer after each accepted beat.
module gpmc_regfile_bridge
  import gpmc_bridge_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] OOR_DATA   = DATA_WIDTH'(16'hBADD)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          gpmc_ad_in,
  output logic [DATA_WIDTH-1:0]          gpmc_ad_out,
  output logic                           gpmc_ad_oe,
  input  logic                           gpmc_csn,
  input  logic                           gpmc_advn,
  input  logic                           gpmc_wein,
  input  logic                           gpmc_oen,
  input  logic [DATA_WIDTH/8-1:0]        gpmc_be_n,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_stb,
  output logic [NUM_REGS-1:0]            reg_rd_stb,
  output logic                           proto_err
);

  gpmc_state_e             r_state;
  logic [ADDR_WIDTH-1:0]   r_addr_ptr;
  gpmc_beat_e              w_beat;
  logic                    w_in_data;
  logic                    w_wr_beat;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_in_range;
  logic                    w_writable;
  logic [NUM_REGS-1:0]     w_onehot;

  assign w_beat     = decode_beat(gpmc_wein, gpmc_oen);
  assign w_in_data  = !gpmc_csn && gpmc_advn && (r_state == ST_DATA);
  assign w_wr_beat  = w_in_data && (w_beat == BEAT_WR);
  assign w_onehot   = NUM_REGS'(1) << r_addr_ptr;
  assign gpmc_ad_oe = !gpmc_csn && gpmc_advn && !gpmc_oen && gpmc_wein;

  gpmc_reg_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .OOR_DATA   (OOR_DATA)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_beat),
    .i_addr     (r_addr_ptr),
    .i_wdata    (gpmc_ad_in),
    .i_be_n     (gpmc_be_n),
    .i_regs_in  (regs_in),
    .o_rdata    (w_rdata),
    .o_in_range (w_in_range),
    .o_writable (w_writable),
    .o_regs_out (regs_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr_ptr  <= '0;
      gpmc_ad_out <= '0;
      reg_wr_stb  <= '0;
      reg_rd_stb  <= '0;
      proto_err   <= 1'b0;
    end else begin
      reg_wr_stb <= '0;
      reg_rd_stb <= '0;
      proto_err  <= 1'b0;
      if (gpmc_csn) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!gpmc_advn) begin
              r_state    <= ST_ADDR;
              r_addr_ptr <= gpmc_ad_in[ADDR_WIDTH-1:0];
            end
          end
          ST_ADDR: begin
            if (gpmc_advn) r_state <= ST_DATA;
            else           r_addr_ptr <= gpmc_ad_in[ADDR_WIDTH-1:0];
          end
          ST_DATA: begin
            if (!gpmc_advn) begin
              r_state    <= ST_ADDR;
              r_addr_ptr <= gpmc_ad_in[ADDR_WIDTH-1:0];
            end else begin
              case (w_beat)
                BEAT_WR: if (w_writable) reg_wr_stb <= w_onehot;
                BEAT_RD: begin
                  gpmc_ad_out <= w_rdata;
                  if (w_in_range) reg_rd_stb <= w_onehot;
                end
                BEAT_ERR: proto_err <= 1'b1;
                default: ;
              endcase
`ifdef GPMC_BURST_EN
              // Pointer advances on every accepted beat, including dropped RO/OOR writes.
              if (w_beat == BEAT_WR || w_beat == BEAT_RD) r_addr_ptr <= r_addr_ptr + 1'b1;
`endif
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
